// File: rtl/step_conditioner_if.sv
// Button/direction/clear inputs and the conditioned step outputs of step_conditioner.
// master drives the raw inputs; slave is the conditioner itself.
interface step_conditioner_if;
    logic btn_in;
    logic dir_in;
    logic clr_in;
    logic step_o;
    logic dir_o;
    logic clr_o;
    logic pressed_o;

    modport master (
        output btn_in, dir_in, clr_in,
        input  step_o, dir_o, clr_o, pressed_o
    );

    modport slave (
        input  btn_in, dir_in, clr_in,
        output step_o, dir_o, clr_o, pressed_o
    );
endinterface

// File: rtl/step_conditioner.sv
// Debounces a raw push-button into single-cycle step pulses for the up/down counter.
// Define STEP_AUTO_REPEAT_EN to add hold-to-repeat stepping.
//   state     | meaning
//   IDLE      | button released and stable
//   ARMING    | button seen high, counting stable cycles before accepting
//   PRESSED   | press accepted, step issued
//   RELEASING | button seen low, counting stable cycles before accepting release
module step_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 4096,
    parameter int REPEAT_PERIOD   = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    step_conditioner_if.slave io
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 2) begin : g_bad_param
        $error("step_conditioner: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ARMING, PRESSED, RELEASING} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [1:0]    btn_sync;
    logic [1:0]    dir_sync;
    logic [1:0]    clr_sync;
    logic          btn_s;
    logic          dir_s;
    logic          clr_s;
    logic          step;
    logic          dir;
    logic          pressed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync <= '0;
            dir_sync <= '0;
            clr_sync <= '0;
        end else begin
            btn_sync <= {btn_sync[0], io.btn_in};
            dir_sync <= {dir_sync[0], io.dir_in};
            clr_sync <= {clr_sync[0], io.clr_in};
        end
    end

    assign btn_s   = btn_sync[1];
    assign dir_s   = dir_sync[1];
    assign clr_s   = clr_sync[1];
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

`ifdef STEP_AUTO_REPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW       = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] HOLD_ONE    = HW'(1);
    localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_last;
    logic          repeating;

    // First repeat waits the long delay, later ones the short period.
    assign hold_last = repeating ? PERIOD_LAST : DELAY_LAST;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            step      <= 1'b0;
            dir       <= 1'b0;
            pressed   <= 1'b0;
`ifdef STEP_AUTO_REPEAT_EN
            hold_cnt  <= '0;
            repeating <= 1'b0;
`endif
        end else begin
            step <= 1'b0;
            if (clr_s) begin
                state     <= IDLE;
                cnt       <= '0;
                pressed   <= 1'b0;
`ifdef STEP_AUTO_REPEAT_EN
                hold_cnt  <= '0;
                repeating <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (btn_s) begin
                            cnt   <= '0;
                            state <= ARMING;
                        end
                    end
                    ARMING: begin
                        if (!btn_s) begin
                            state <= IDLE;
                        end else if (cnt == CNT_LAST) begin
                            cnt       <= CNT_MAX;
                            state     <= PRESSED;
                            step      <= 1'b1;
                            dir       <= dir_s;
                            pressed   <= 1'b1;
`ifdef STEP_AUTO_REPEAT_EN
                            hold_cnt  <= '0;
                            repeating <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    PRESSED: begin
                        if (!btn_s) begin
                            cnt       <= '0;
                            state     <= RELEASING;
`ifdef STEP_AUTO_REPEAT_EN
                            hold_cnt  <= '0;
                            repeating <= 1'b0;
`endif
                        end
`ifdef STEP_AUTO_REPEAT_EN
                        else if (hold_cnt == hold_last) begin
                            hold_cnt  <= '0;
                            repeating <= 1'b1;
                            step      <= 1'b1;
                            dir       <= dir_s;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_ONE;
                        end
`endif
                    end
                    RELEASING: begin
                        if (btn_s) begin
                            state <= PRESSED;
                        end else if (cnt == CNT_LAST) begin
                            cnt     <= CNT_MAX;
                            state   <= IDLE;
                            pressed <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign io.step_o    = step;
    assign io.dir_o     = dir;
    assign io.clr_o     = clr_s;
    assign io.pressed_o = pressed;

endmodule

// File: tb/tb_step_conditioner.sv
// Directed bench for step_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Edge numbering: inputs change 1ns after an edge, so the next rising edge is E0.
module tb_step_conditioner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    step_conditioner_if bus();

    step_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        int steps;
        int pos;
        bus.btn_in = 1'b1;
        bus.dir_in = 1'b1;
        bus.clr_in = 1'b1;
        rst_n = 1'b0;
        wait_cycles(3);
        vectors++; if (bus.step_o !== 1'b0) begin miscompares++; $display("FAIL reset_step: got %b expected 0", bus.step_o); end
        vectors++; if (bus.dir_o !== 1'b0) begin miscompares++; $display("FAIL reset_dir: got %b expected 0", bus.dir_o); end
        vectors++; if (bus.clr_o !== 1'b0) begin miscompares++; $display("FAIL reset_clr: got %b expected 0", bus.clr_o); end
        vectors++; if (bus.pressed_o !== 1'b0) begin miscompares++; $display("FAIL reset_pressed: got %b expected 0", bus.pressed_o); end
        bus.clr_in = 1'b0;
        bus.dir_in = 1'b0;
        tick();
        rst_n = 1'b1;
        steps = 0;
        pos = -1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.step_o === 1'b1) begin steps++; pos = i; end
        end
        vectors++; if (steps !== 1) begin miscompares++; $display("FAIL reset_release_steps: got %0d expected 1", steps); end
        vectors++; if (pos !== 6) begin miscompares++; $display("FAIL reset_release_edge: got %0d expected 6", pos); end
        vectors++; if (bus.dir_o !== 1'b0) begin miscompares++; $display("FAIL reset_release_dir: got %b expected 0", bus.dir_o); end
        bus.btn_in = 1'b0;
        wait_cycles(12);
    endtask

    task automatic test_clean_press();
        int steps;
        int first;
        int exp_steps;
`ifdef STEP_AUTO_REPEAT_EN
        exp_steps = 2;
`else
        exp_steps = 1;
`endif
        steps = 0;
        first = -1;
        bus.dir_in = 1'b1;
        bus.btn_in = 1'b1;
        for (int i = 0; i < 46; i++) begin
            tick();
            if (bus.step_o === 1'b1) begin
                if (first < 0) first = i;
                steps++;
            end
            if (i == 5) begin
                vectors++; if (bus.pressed_o !== 1'b0) begin miscompares++; $display("FAIL press_pressed_e5: got %b expected 0", bus.pressed_o); end
            end
            if (i == 6) begin
                vectors++; if (bus.pressed_o !== 1'b1) begin miscompares++; $display("FAIL press_pressed_e6: got %b expected 1", bus.pressed_o); end
                vectors++; if (bus.dir_o !== 1'b1) begin miscompares++; $display("FAIL press_dir: got %b expected 1", bus.dir_o); end
            end
            if (i == 29) bus.btn_in = 1'b0;
            if (i == 35) begin
                vectors++; if (bus.pressed_o !== 1'b1) begin miscompares++; $display("FAIL release_pressed_e35: got %b expected 1", bus.pressed_o); end
            end
            if (i == 36) begin
                vectors++; if (bus.pressed_o !== 1'b0) begin miscompares++; $display("FAIL release_pressed_e36: got %b expected 0", bus.pressed_o); end
            end
        end
        vectors++; if (first !== 6) begin miscompares++; $display("FAIL press_step_edge: got %0d expected 6", first); end
        vectors++; if (steps !== exp_steps) begin miscompares++; $display("FAIL press_step_count: got %0d expected %0d", steps, exp_steps); end
    endtask

    task automatic test_glitch();
        int steps;
        int pressed_seen;
        steps = 0;
        pressed_seen = 0;
        bus.btn_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 2) bus.btn_in = 1'b0;
            if (bus.step_o === 1'b1) steps++;
            if (bus.pressed_o !== 1'b0) pressed_seen++;
        end
        vectors++; if (steps !== 0) begin miscompares++; $display("FAIL glitch_steps: got %0d expected 0", steps); end
        vectors++; if (pressed_seen !== 0) begin miscompares++; $display("FAIL glitch_pressed: got %0d cycles expected 0", pressed_seen); end
    endtask

    task automatic test_release_bounce();
        int steps;
        int extra;
        int pos;
        steps = 0;
        bus.dir_in = 1'b1;
        bus.btn_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.step_o === 1'b1) steps++;
        end
        vectors++; if (steps !== 1) begin miscompares++; $display("FAIL bounce_press_steps: got %0d expected 1", steps); end
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            bus.btn_in = ((k / 2) % 2) == 1;
            tick();
            if (bus.step_o === 1'b1) extra++;
        end
        bus.btn_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.step_o === 1'b1) extra++;
        end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL bounce_extra_steps: got %0d expected 0", extra); end
        vectors++; if (bus.pressed_o !== 1'b0) begin miscompares++; $display("FAIL bounce_settled_pressed: got %b expected 0", bus.pressed_o); end
        vectors++; if (bus.dir_o !== 1'b1) begin miscompares++; $display("FAIL bounce_dir_held: got %b expected 1", bus.dir_o); end
        bus.dir_in = 1'b0;
        bus.btn_in = 1'b1;
        steps = 0;
        pos = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.step_o === 1'b1) begin steps++; pos = i; end
        end
        vectors++; if (steps !== 1) begin miscompares++; $display("FAIL repress_steps: got %0d expected 1", steps); end
        vectors++; if (pos !== 6) begin miscompares++; $display("FAIL repress_edge: got %0d expected 6", pos); end
        vectors++; if (bus.dir_o !== 1'b0) begin miscompares++; $display("FAIL repress_dir: got %b expected 0", bus.dir_o); end
        bus.btn_in = 1'b0;
        wait_cycles(12);
    endtask

    task automatic test_clear_priority();
        int steps;
        int pos;
        int pressed_seen;
        steps = 0;
        pos = -1;
        pressed_seen = 0;
        bus.btn_in = 1'b1;
        for (int i = 0; i < 28; i++) begin
            tick();
            if (bus.step_o === 1'b1) begin steps++; pos = i; end
            if (i >= 4 && i <= 14 && bus.pressed_o !== 1'b0) pressed_seen++;
            if (i == 3) bus.clr_in = 1'b1;
            if (i == 4) begin
                vectors++; if (bus.clr_o !== 1'b0) begin miscompares++; $display("FAIL clr_latency_e4: got %b expected 0", bus.clr_o); end
            end
            if (i == 5) begin
                vectors++; if (bus.clr_o !== 1'b1) begin miscompares++; $display("FAIL clr_latency_e5: got %b expected 1", bus.clr_o); end
            end
            if (i == 6) begin
                vectors++; if (bus.step_o !== 1'b0) begin miscompares++; $display("FAIL clr_blocks_step: got %b expected 0", bus.step_o); end
            end
            if (i == 11) bus.clr_in = 1'b0;
            if (i == 13) begin
                vectors++; if (bus.clr_o !== 1'b0) begin miscompares++; $display("FAIL clr_drop: got %b expected 0", bus.clr_o); end
            end
        end
        vectors++; if (pressed_seen !== 0) begin miscompares++; $display("FAIL clr_pressed: got %0d cycles expected 0", pressed_seen); end
        vectors++; if (steps !== 1) begin miscompares++; $display("FAIL clr_after_steps: got %0d expected 1", steps); end
        vectors++; if (pos !== 18) begin miscompares++; $display("FAIL clr_after_edge: got %0d expected 18", pos); end
        bus.btn_in = 1'b0;
        wait_cycles(12);
    endtask

    task automatic test_hold();
        int steps;
        int pos[8];
        int exp_pos[4];
        int exp_n;
`ifdef STEP_AUTO_REPEAT_EN
        exp_n = 4;
        exp_pos[0] = 6; exp_pos[1] = 26; exp_pos[2] = 34; exp_pos[3] = 42;
`else
        exp_n = 1;
        exp_pos[0] = 6; exp_pos[1] = -1; exp_pos[2] = -1; exp_pos[3] = -1;
`endif
        steps = 0;
        for (int i = 0; i < 8; i++) pos[i] = -1;
        bus.dir_in = 1'b1;
        bus.btn_in = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.step_o === 1'b1) begin
                if (steps < 8) pos[steps] = i;
                steps++;
            end
            if (i == 45) bus.btn_in = 1'b0;
        end
        vectors++; if (steps !== exp_n) begin miscompares++; $display("FAIL hold_step_count: got %0d expected %0d", steps, exp_n); end
        for (int j = 0; j < exp_n; j++) begin
            vectors++; if (pos[j] !== exp_pos[j]) begin miscompares++; $display("FAIL hold_step_edge[%0d]: got %0d expected %0d", j, pos[j], exp_pos[j]); end
        end
        vectors++; if (bus.dir_o !== 1'b1) begin miscompares++; $display("FAIL hold_dir: got %b expected 1", bus.dir_o); end
        wait_cycles(6);
    endtask

    task automatic test_reset_abort();
        int steps;
        bus.dir_in = 1'b1;
        bus.btn_in = 1'b1;
        wait_cycles(8);
        vectors++; if (bus.pressed_o !== 1'b1) begin miscompares++; $display("FAIL abort_pre_pressed: got %b expected 1", bus.pressed_o); end
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.pressed_o !== 1'b0) begin miscompares++; $display("FAIL abort_pressed: got %b expected 0", bus.pressed_o); end
        vectors++; if (bus.dir_o !== 1'b0) begin miscompares++; $display("FAIL abort_dir: got %b expected 0", bus.dir_o); end
        bus.btn_in = 1'b0;
        tick();
        rst_n = 1'b1;
        steps = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.step_o === 1'b1) steps++;
        end
        vectors++; if (steps !== 0) begin miscompares++; $display("FAIL abort_release_steps: got %0d expected 0", steps); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_release_bounce();
        test_clear_priority();
        test_hold();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
